// File: rtl/sid_waveform_mixer_if.sv
// Waveform mixer bus: per-voice raw waveforms and phase in, DAC value and OSC3 readback out.
interface sid_waveform_mixer_if #(
  parameter int PHASE_W = 4
);
  logic               model;    // 0 = MOS6581, 1 = MOS8580
  logic [PHASE_W-1:0] phase;    // one-hot SID cycle phase
  logic [3:0]         sel;      // {N,P,S,T}
  logic [7:0]         noise;
  logic               pulse;
  logic [11:0]        saw_tri;
  logic [11:0]        wav;
  logic [7:0]         osc3;

  modport master (output model, phase, sel, noise, pulse, saw_tri,
                  input  wav, osc3);
  modport slave  (input  model, phase, sel, noise, pulse, saw_tri,
                  output wav, osc3);
endinterface

// File: rtl/sid_waveform_mixer.sv
// SID waveform mixer: single/combined waveform selection with floating-DAC hold.
// Optional macro SID_WAVEFORM_FADE_EN: fade the held value by halving instead of dropping to zero.
module sid_waveform_mixer #(
  parameter logic [23:0] HOLD_6581 = 24'd10000,
  parameter logic [23:0] HOLD_8580 = 24'd1000000,
  parameter string       ROM_FILE  = "sid_wav_comb.hex",
  parameter int          PHASE_W   = 4,
  parameter int          PHI1_PHI2 = 1
)(
  input  logic                  clk,
  input  logic                  res,
  sid_waveform_mixer_if.slave   bus
);
  localparam int STAGES    = 3;
  localparam int ROM_DEPTH = 2 * 4 * 4096;

  // Combined-waveform table {model, combo, saw_tri}; preloaded with ROM_FILE contents by the
  // integration flow, zero until then.
  logic [7:0] rom [ROM_DEPTH] = '{default: 8'h00};

  logic [STAGES-1:0] vld_pipe;
  logic [3:0]  sel_r;
  logic [7:0]  noise_r;
  logic        pulse_r;
  logic [11:0] saw_tri_r;
  logic        model_r;
  logic [7:0]  rom_q;
  logic [11:0] comb_r;
  logic [23:0] cnt, cnt_next, cnt_inc, limit;
  logic [11:0] wav_r, wav_next;
  logic [7:0]  osc3_r;

  logic [1:0]  combo;
  logic [14:0] rom_addr;
  logic [11:0] tri_w, pul_w, noi_w, comb_w, base_w;

  // ST=0, PT=1, PS=2, PST=3 falls straight out of the P/S and P/T pair bits.
  assign combo    = {bus.sel[2] & bus.sel[1], bus.sel[2] & bus.sel[0]};
  assign rom_addr = {bus.model, combo, bus.saw_tri};

  always_ff @(posedge clk)
    if (vld_pipe[0]) rom_q <= rom[rom_addr];

  assign tri_w  = {saw_tri_r[10:0], 1'b0};
  assign pul_w  = {12{pulse_r}};
  assign noi_w  = {noise_r, 4'b0};
  assign comb_w = {rom_q, 4'b0} & (sel_r[2] ? pul_w : 12'hFFF);
  assign limit  = model_r ? HOLD_8580 : HOLD_6581;
  assign cnt_inc = (cnt >= limit) ? limit : cnt + 24'd1;

  always_comb begin
    wav_next = wav_r;
    cnt_next = cnt;
    case (sel_r[2:0])
      3'b001:  base_w = tri_w;
      3'b010:  base_w = saw_tri_r;
      3'b100:  base_w = pul_w;
      default: base_w = comb_r;
    endcase
    if (sel_r == 4'b0000) begin
      cnt_next = cnt_inc;
      if (cnt_inc == limit) begin
`ifdef SID_WAVEFORM_FADE_EN
        wav_next = wav_r >> 1;
`else
        wav_next = 12'h000;
`endif
      end
    end else begin
      cnt_next = '0;
      if (sel_r[3])
        wav_next = (sel_r[2:0] == 3'b000) ? noi_w : (noi_w & base_w);
      else
        wav_next = base_w;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      vld_pipe  <= '0;
      sel_r     <= '0;
      noise_r   <= '0;
      pulse_r   <= 1'b0;
      saw_tri_r <= '0;
      model_r   <= 1'b0;
      comb_r    <= '0;
      cnt       <= '0;
      wav_r     <= '0;
      osc3_r    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.phase[PHI1_PHI2]};
      if (vld_pipe[0]) begin
        sel_r     <= bus.sel;
        noise_r   <= bus.noise;
        pulse_r   <= bus.pulse;
        saw_tri_r <= bus.saw_tri;
        model_r   <= bus.model;
      end
      if (vld_pipe[1]) comb_r <= comb_w;
      if (vld_pipe[2]) begin
        wav_r  <= wav_next;
        osc3_r <= wav_next[11:4];
        cnt    <= cnt_next;
      end
    end
  end

  assign bus.wav  = wav_r;
  assign bus.osc3 = osc3_r;
endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Scoreboard bench for sid_waveform_mixer: directed SID cycles, monitor checks 3 clk after sync.
module tb_sid_waveform_mixer;
  localparam int PHASE_W = 4;
  localparam int PHI = 1;
`ifdef SID_WAVEFORM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  sid_waveform_mixer_if #(.PHASE_W(PHASE_W)) bus ();

  sid_waveform_mixer #(
    .HOLD_6581(24'd4), .HOLD_8580(24'd6), .ROM_FILE("sid_wav_comb.hex"),
    .PHASE_W(PHASE_W), .PHI1_PHI2(PHI)
  ) dut (.clk(clk), .res(res), .bus(bus));

  typedef struct { logic [11:0] wav; logic [7:0] osc3; string name; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [3:0]  mon_pipe;
  logic [11:0] last_wav;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk)
    if (res) mon_pipe <= '0;
    else     mon_pipe <= {mon_pipe[2:0], bus.phase[PHI]};

  // Monitor: one edge early the old value must still be present, on the result edge pop and compare.
  always @(negedge clk) begin
    if (res) last_wav = 12'h000;
    else if (mon_pipe[2]) check("latency_hold", bus.wav, last_wav);
    else if (mon_pipe[3]) begin
      if (sb.size() == 0) check("sb_underflow", 12'h001, 12'h000);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_wav"}, bus.wav, e.wav);
        check({e.name, "_osc3"}, {4'h0, bus.osc3}, {4'h0, e.osc3});
        last_wav = e.wav;
      end
    end
  end

  task automatic cyc(input logic m, input logic [3:0] s, input logic [7:0] n, input logic p,
                     input logic [11:0] st, input logic [11:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    bus.model = m; bus.sel = s; bus.noise = n; bus.pulse = p; bus.saw_tri = st;
    bus.phase = 4'b0010;
    e.wav = exp; e.osc3 = exp[11:4]; e.name = name;
    sb.push_back(e);
    @(negedge clk) bus.phase = 4'b0100;
    @(negedge clk) bus.phase = 4'b1000;
    @(negedge clk) bus.phase = 4'b0001;
  endtask

  initial begin
    res = 1'b1;
    bus.model = 1'b0; bus.sel = 4'h0; bus.noise = 8'h00; bus.pulse = 1'b0;
    bus.saw_tri = 12'h000; bus.phase = 4'b0001;
    for (int i = 0; i < 2 * 4 * 4096; i++) dut.rom[i] = 8'(i);
    repeat (2) @(negedge clk);
    check("rst_wav", bus.wav, 12'h000);
    check("rst_osc3", {4'h0, bus.osc3}, 12'h000);
    res = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_wav", bus.wav, 12'h000);
    check("idle_osc3", {4'h0, bus.osc3}, 12'h000);

    cyc(0, 4'b0010, 8'h00, 0, 12'hABC, 12'hABC, "saw");
    cyc(0, 4'b0001, 8'h00, 0, 12'h801, 12'h002, "tri");
    cyc(0, 4'b0100, 8'h00, 1, 12'h123, 12'hFFF, "pul1");
    cyc(0, 4'b0100, 8'h00, 0, 12'h123, 12'h000, "pul0");
    cyc(0, 4'b0111, 8'h00, 1, 12'hFFF, 12'hFF0, "pst_p1");
    cyc(0, 4'b0111, 8'h00, 0, 12'hFFF, 12'h000, "pst_p0");
    cyc(1, 4'b0110, 8'h00, 1, 12'h123, 12'h230, "ps_8580");
    cyc(0, 4'b0011, 8'h00, 0, 12'h0C5, 12'hC50, "st_nopul");
    cyc(0, 4'b1000, 8'h5A, 0, 12'h000, 12'h5A0, "noise");
    cyc(0, 4'b1010, 8'h5A, 0, 12'hFFF, 12'h5A0, "ns_fff");
    cyc(0, 4'b1010, 8'h5A, 0, 12'h000, 12'h000, "ns_0");

    // 6581 hold, limit 4
    cyc(0, 4'b0010, 8'h00, 0, 12'h800, 12'h800, "h1_load");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, 12'h800, "h1_c1");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, 12'h800, "h1_c2");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, 12'h800, "h1_c3");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, FADE ? 12'h400 : 12'h000, "h1_c4");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, FADE ? 12'h200 : 12'h000, "h1_c5");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, FADE ? 12'h100 : 12'h000, "h1_c6");
    // nonzero sel clears the counter; 8580 limit 6
    cyc(1, 4'b0010, 8'h00, 0, 12'h600, 12'h600, "h2_load");
    for (int i = 1; i <= 5; i++)
      cyc(1, 4'b0000, 8'h00, 0, 12'h000, 12'h600, "h2_hold");
    cyc(1, 4'b0000, 8'h00, 0, 12'h000, FADE ? 12'h300 : 12'h000, "h2_c6");
    // model switch mid-hold keeps the count, new limit applies at once
    cyc(1, 4'b0010, 8'h00, 0, 12'hFFF, 12'hFFF, "h3_load");
    cyc(1, 4'b0000, 8'h00, 0, 12'h000, 12'hFFF, "h3_c1");
    cyc(1, 4'b0000, 8'h00, 0, 12'h000, 12'hFFF, "h3_c2");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, 12'hFFF, "h3_c3");
    cyc(0, 4'b0000, 8'h00, 0, 12'h000, FADE ? 12'h7FF : 12'h000, "h3_c4");

    // reset in the middle of a pass: no partial write afterwards
    cyc(0, 4'b0010, 8'h00, 0, 12'hABC, 12'hABC, "pre_rst");
    @(negedge clk);
    bus.sel = 4'b0010; bus.saw_tri = 12'h321; bus.phase = 4'b0010;
    @(negedge clk) bus.phase = 4'b0100;
    @(negedge clk) begin bus.phase = 4'b1000; res = 1'b1; end
    @(negedge clk);
    check("midrst_wav", bus.wav, 12'h000);
    res = 1'b0; bus.phase = 4'b0001;
    @(negedge clk);
    check("midrst_nowrite", bus.wav, 12'h000);
    @(negedge clk);
    check("midrst_osc3", {4'h0, bus.osc3}, 12'h000);
    cyc(0, 4'b0001, 8'h00, 0, 12'h801, 12'h002, "post_rst");

    for (int i = 0; i < 16 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("sb_drain", 12'(sb.size()), 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
